// File: rtl/round_judge.sv
// round_judge: one game round -- latch prompt, await key or timeout, judge, emit held incr pulse.
// Optional macro ROUND_SPEEDUP_EN shrinks the timeout after each correct answer.
module round_judge #(
  parameter int TIMEOUT_CYCLES = 50000000,
  parameter int TIMER_W = 26,
  parameter int HOLD_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [1:0] prompt_dir,
  input  logic [1:0] prompt_not,
  input  logic [3:0] key,
  input  logic       dead,
  output logic       point_incr,
  output logic       life_incr,
  output logic       busy,
  output logic       round_done,
  output logic       result
);
  typedef enum logic [2:0] {IDLE, ARM, WAIT, JUDGE, PULSE, RELEASE} state_t;
  localparam int CW = $clog2(HOLD_CYCLES + 2);
  state_t state, state_n;
  logic [TIMER_W-1:0] timer, last;
  logic [CW-1:0] cnt;
  logic [1:0] dir_q, not_q;
  logic [3:0] key_q;
  logic correct;
  assign correct = (key_q != 4'd0) && ((key_q & (key_q - 4'd1)) == 4'd0) && (key_q[dir_q] ^ not_q[0]);
`ifdef ROUND_SPEEDUP_EN
  localparam logic [TIMER_W-1:0] FULL = TIMER_W'(TIMEOUT_CYCLES);
  localparam logic [TIMER_W-1:0] STEP = TIMER_W'(TIMEOUT_CYCLES >> 3);
  localparam logic [TIMER_W-1:0] FLOOR = TIMER_W'(TIMEOUT_CYCLES >> 2);
  logic [TIMER_W-1:0] limit;
  always_ff @(posedge clk)
    if (!reset_n) limit <= FULL;
    else if (state == JUDGE && correct) limit <= (limit < FLOOR + STEP) ? FLOOR : limit - STEP;
  assign last = limit - TIMER_W'(1);
`else
  assign last = TIMER_W'(TIMEOUT_CYCLES - 1);
`endif
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt <= '0;
      timer <= '0;
      dir_q <= '0;
      not_q <= '0;
      key_q <= '0;
      result <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= (state_n != state) ? '0 : cnt + CW'(1);
      if (state == IDLE && start && !dead) begin
        dir_q <= prompt_dir;
        not_q <= prompt_not;
        result <= 1'b0;
      end
      if (state == ARM) timer <= '0;
      else if (state == WAIT && state_n == WAIT) timer <= timer + TIMER_W'(1);
      if (state == WAIT) key_q <= key;
      if (state == JUDGE) result <= correct;
    end
  end
  // a key press on the final timer cycle still wins because key_q captures it
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = (start && !dead) ? ARM : IDLE;
      ARM:     state_n = (key == 4'd0) ? WAIT : ARM;
      WAIT:    state_n = (key != 4'd0 || timer == last) ? JUDGE : WAIT;
      JUDGE:   state_n = PULSE;
      PULSE:   state_n = (cnt == CW'(HOLD_CYCLES - 1)) ? RELEASE : PULSE;
      RELEASE: state_n = (cnt == CW'(1)) ? IDLE : RELEASE;
      default: state_n = IDLE;
    endcase
    busy = state != IDLE;
    point_incr = state == PULSE && result;
    life_incr = state == PULSE && !result;
    round_done = state == PULSE && cnt == '0;
  end
endmodule

// File: tb/tb_round_judge.sv
// tb_round_judge: directed checks of round_judge with a 16-cycle timeout and 4-cycle hold.
module tb_round_judge;
  logic clk = 0, reset_n = 0, start = 0, dead = 0;
  logic [1:0] prompt_dir = 0, prompt_not = 0;
  logic [3:0] key = 0;
  logic point_incr, life_incr, busy, round_done, result;
  int n_chk = 0, n_fail = 0;

  round_judge #(.TIMEOUT_CYCLES(16), .TIMER_W(5), .HOLD_CYCLES(4)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .prompt_dir(prompt_dir),
    .prompt_not(prompt_not), .key(key), .dead(dead), .point_incr(point_incr),
    .life_incr(life_incr), .busy(busy), .round_done(round_done), .result(result));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // start a round, wait d WAIT cycles, then present key k for one cycle; ends in JUDGE
  task automatic go(input logic [1:0] d_in, input logic [1:0] n_in, input logic [3:0] k, input int d);
    prompt_dir = d_in; prompt_not = n_in; start = 1;
    tick(); start = 0;
    chk("arm_busy", busy, 1);
    tick();
    repeat (d) tick();
    key = k;
    tick(); key = 0;
    chk("judge_no_incr", {point_incr, life_incr}, 0);
  endtask

  task automatic pulse(input string tag, input logic exp);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk({tag, "_point"}, point_incr, exp);
      chk({tag, "_life"}, life_incr, !exp);
      chk({tag, "_done"}, round_done, i == 0);
      if (i == 0) chk({tag, "_result"}, result, exp);
    end
    tick();
    chk({tag, "_rel_low"}, {point_incr, life_incr, busy}, 3'b001);
    tick();
    chk({tag, "_rel_busy"}, busy, 1);
    tick();
    chk({tag, "_idle"}, busy, 0);
  endtask

  // measure WAIT cycles before a timeout verdict appears
  task automatic tmo(input string tag, input int len);
    int j = 0;
    start = 1; prompt_dir = 0; prompt_not = 0;
    tick(); start = 0;
    tick();
    while (!life_incr && j < 40) begin tick(); j++; end
    chk(tag, j, len + 1);
    repeat (6) tick();
    chk({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    tick(); tick();
    chk("rst_out", {point_incr, life_incr, busy, round_done, result}, 0);
    reset_n = 1;
    tick();
    chk("idle", busy, 0);
    go(2, 0, 4'b0100, 0); pulse("even_hit", 1);
    go(2, 1, 4'b0100, 0); pulse("odd_hit", 0);
    go(2, 1, 4'b0001, 0); pulse("odd_miss", 1);
    go(2, 2, 4'b0100, 0); pulse("not2_hit", 1);
    go(0, 0, 4'b0010, 3); pulse("even_miss", 0);
    go(3, 3, 4'b0100, 1); pulse("not3_miss", 1);
    go(1, 0, 4'b0000, 15);
    chk("tmo_busy", busy, 1);
    pulse("timeout", 0);
    go(2, 0, 4'b0100, 15); pulse("tie_key", 1);
    key = 4'b0001; prompt_dir = 0; prompt_not = 0; start = 1;
    tick(); start = 0;
    repeat (20) tick();
    chk("held_arm", {busy, point_incr, life_incr}, 3'b100);
    key = 0; tick();
    key = 4'b0011; tick(); key = 0;
    pulse("multi", 0);
    dead = 1; start = 1;
    tick(); chk("dead_blk", busy, 0);
    tick(); chk("dead_blk2", busy, 0);
    dead = 0; start = 0;
    go(2, 0, 4'b0100, 0);
    tick(); start = 1;
    tick(); chk("pls_start1", point_incr, 1);
    tick(); chk("pls_start2", point_incr, 1);
    start = 0;
    repeat (4) tick();
    chk("pls_start_idle", busy, 0);
    go(2, 0, 4'b0100, 0);
    tick(); chk("pre_rst", point_incr, 1);
    reset_n = 0;
    tick();
    chk("mid_rst", {point_incr, life_incr, busy, result}, 0);
    reset_n = 1; tick();
    tmo("tmo_a", 16);
    go(2, 0, 4'b0100, 0); pulse("c1", 1);
`ifdef ROUND_SPEEDUP_EN
    tmo("tmo_b", 14);
    go(2, 0, 4'b0100, 0); pulse("c2", 1);
    tmo("tmo_c", 12);
    repeat (5) begin go(2, 0, 4'b0100, 0); pulse("cn", 1); end
    tmo("tmo_floor", 4);
    reset_n = 0; tick(); reset_n = 1; tick();
    tmo("tmo_rst", 16);
`else
    tmo("tmo_fixed", 16);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/round_judge.md
Name: round_judge

Overview:
- Upstream stage of the point/lives counters.
- Runs one game round: latches a prompt (direction plus negation count), waits for the player's key press or a timeout, and judges the answer.
- Emits a held-level pulse on point_incr (correct) or life_incr (wrong); the downstream counter control acts on the falling edge of that pulse.

Parameters:
- TIMEOUT_CYCLES, 50000000: cycles allowed for an answer (1 s at 50 MHz).
- TIMER_W, 26: round timer width; must satisfy 2^TIMER_W > TIMEOUT_CYCLES.
- HOLD_CYCLES, 4: cycles point_incr/life_incr stay high (≥1).

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- start  in  1  begin a round; sampled only in IDLE
- prompt_dir  in  2  0=up 1=down 2=left 3=right; latched on accepted start
- prompt_not  in  2  negation count; latched on accepted start
- key  in  4  one bit per direction, index = direction code, active-high, already synchronised/debounced
- dead  in  1  player out of lives
- point_incr  out  1  correct-answer level pulse
- life_incr  out  1  wrong-answer level pulse
- busy  out  1  high in every state except IDLE
- round_done  out  1  one-cycle strobe on entry to PULSE
- result  out  1  1=correct, 0=wrong; valid from round_done until the next accepted start

Behaviour:
- Reset (reset_n low at a clk edge, any state): state=IDLE, all outputs 0, timer 0, latched prompt 0. Applies mid-round; a pulse in progress is cut off.
- IDLE: start=1 and dead=0 -> latch prompt_dir/prompt_not, go to ARM. start is ignored when dead=1 or when not in IDLE.
- ARM: wait for key==0, so a key held over from the last round does not count. key==0 -> clear timer, go to WAIT. No timeout in ARM.
- WAIT: timer increments every cycle.
  - Any key bit high -> capture key, go to JUDGE.
  - Timer reaches TIMEOUT_CYCLES-1 with key==0 -> timeout, go to JUDGE.
  - Key and last timer cycle coincide -> key wins.
- JUDGE (1 cycle), with parity = prompt_not[0] (0, 2 even; 1, 3 odd):
  - Exactly one key bit set, even parity: correct iff that bit equals the latched dir.
  - Exactly one key bit set, odd parity: correct iff that bit differs from the latched dir.
  - More than one key bit set: wrong.
  - Timeout: wrong for both parities.
  - Sets result; goes to PULSE.
- PULSE: asserts point_incr (correct) or life_incr (wrong) for exactly HOLD_CYCLES cycles.
  - round_done is high on the first of those cycles.
  - Never both incr outputs high together.
- RELEASE: both incr outputs low for 2 cycles, then IDLE. This guarantees the ≥2-cycle low gap the counter control needs between pulses.
- dead rising mid-round: the round completes normally. Only new starts are blocked.
- Latency:
  - start to ARM: 1 cycle.
  - Key press in WAIT to first incr cycle: 2 cycles (WAIT->JUDGE->PULSE).
- Timer arithmetic is unsigned. It never wraps because it is cleared on leaving ARM and stopped at TIMEOUT_CYCLES-1.

Optional Feature:
- Macro ROUND_SPEEDUP_EN.
- Defined:
  - Holds a reload register limit, reset to TIMEOUT_CYCLES.
  - WAIT times out at limit-1 instead of TIMEOUT_CYCLES-1.
  - Each correct judgement sets limit = limit - (TIMEOUT_CYCLES>>3), floored at TIMEOUT_CYCLES>>2.
  - Wrong answers leave limit unchanged.
  - Reset restores limit to TIMEOUT_CYCLES.
- Undefined: timeout is fixed at TIMEOUT_CYCLES and no limit register exists.

Test Plan:
(All with TIMEOUT_CYCLES=16, HOLD_CYCLES=4.)
- Correct, even parity: start with dir=2, not=0; key=4'b0100 in WAIT -> point_incr high 4 cycles starting 2 cycles after the key, result=1, life_incr stays 0.
- Odd parity: start with dir=2, not=1; key=4'b0100 -> life_incr 4 cycles. Repeat with key=4'b0001 -> point_incr 4 cycles. With not=2 and key=4'b0100 -> point_incr.
- Timeout and tie:
  - No key for 16 WAIT cycles -> life_incr, result=0.
  - Key on the 16th WAIT cycle -> judged as key, not timeout.
- Key held across start: key=4'b0001 held; start -> busy=1, stays in ARM (no timer) until key=0.
  - Multi-key 4'b0011 -> life_incr.
- Gating:
  - start with dead=1 -> busy stays 0.
  - start during PULSE -> ignored.
  - reset_n=0 during PULSE -> point_incr 0 next cycle, busy=0.
- ROUND_SPEEDUP_EN:
  - Three correct rounds -> timeouts of 16, 14, 12 WAIT cycles.
  - Eventually floors at 4.
  - Reset restores 16.
